traffic_detect: RTL and testbench



---
 rtl/traffic_detect.sv | 171 +++++++++++++++++
 tb/tb_traffic_detect.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_detect.sv
// traffic_detect: counts vehicles inside a blink-timed window and raises the
// traffic request for control; the request is held until control acknowledges.
// Ports: clk, rstb (async, active low), blink, inVehicle, inAck
//        -> outTraffic, outCount (saturating total), outTimeout.
// Optional macro TRAFFIC_DETECT_TIMEOUT_EN: an unacknowledged request is dropped
// after C_REQ_TIMEOUT blinks and the sticky outTimeout flag is set.
module traffic_detect #(
  parameter int C_THRESHOLD   = 3,
  parameter int C_WINDOW      = 50,
  parameter int C_HOLDOFF     = 20,
  parameter int C_REQ_TIMEOUT = 100,
  parameter int C_CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               blink,
  input  logic               inVehicle,
  input  logic               inAck,
  output logic               outTraffic,
  output logic [C_CNT_W-1:0] outCount,
  output logic               outTimeout
);

  // tmr is shared by window, holdoff and timeout, so size it for the longest
  localparam int M1 =
    (C_WINDOW > C_HOLDOFF) ? C_WINDOW : C_HOLDOFF;
  localparam int TMR_MAX =
    (M1 > C_REQ_TIMEOUT) ? M1 : C_REQ_TIMEOUT;
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam int VW = $clog2(C_THRESHOLD + 1);

  localparam logic [VW-1:0] THR = VW'(C_THRESHOLD);
  localparam logic [TW-1:0] WIN = TW'(C_WINDOW);
  localparam logic [TW-1:0] HLD = TW'(C_HOLDOFF);
`ifdef TRAFFIC_DETECT_TIMEOUT_EN
  localparam logic [TW-1:0] RTO = TW'(C_REQ_TIMEOUT);
`endif

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REQUEST,
    HOLDOFF
  } state_t;

  state_t          state;
  logic            blink_s1;
  logic            blink_s2;
  logic            veh_s1;
  logic            veh_s2;
  logic            tick;
  logic            veh;
  logic [VW-1:0]   veh_cnt;
  logic [VW-1:0]   veh_nxt;
  logic [TW-1:0]   tmr;
  logic [TW-1:0]   tmr_nxt;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      blink_s1 <= 1'b0;
      blink_s2 <= 1'b0;
      veh_s1   <= 1'b0;
      veh_s2   <= 1'b0;
    end else begin
      blink_s1 <= blink;
      blink_s2 <= blink_s1;
      veh_s1   <= inVehicle;
      veh_s2   <= veh_s1;
    end
  end

  assign tick    = blink_s1 & ~blink_s2;
  assign veh     = veh_s1 & ~veh_s2;
  assign veh_nxt = veh_cnt + 1'b1;
  assign tmr_nxt = tmr + 1'b1;

  // total vehicle count runs in every state and sticks at all-ones
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      outCount <= '0;
    end else if (veh && (outCount != '1)) begin
      outCount <= outCount + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      outTraffic <= 1'b0;
      veh_cnt    <= '0;
      tmr        <= '0;
`ifdef TRAFFIC_DETECT_TIMEOUT_EN
      outTimeout <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (veh) begin
            veh_cnt <= VW'(1);
            tmr     <= '0;
            if (C_THRESHOLD == 1) begin
              state      <= REQUEST;
              outTraffic <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          // threshold is checked first so a vehicle on the
          // expiring tick still raises the request
          if (veh && (veh_nxt == THR)) begin
            state      <= REQUEST;
            outTraffic <= 1'b1;
            veh_cnt    <= THR;
            tmr        <= '0;
          end else if (tick && (tmr_nxt == WIN)) begin
            state   <= IDLE;
            veh_cnt <= '0;
            tmr     <= '0;
          end else begin
            if (veh) veh_cnt <= veh_nxt;
            if (tick) tmr <= tmr_nxt;
          end
        end
        REQUEST: begin
          if (inAck) begin
            state      <= HOLDOFF;
            outTraffic <= 1'b0;
            tmr        <= '0;
            veh_cnt    <= '0;
          end
`ifdef TRAFFIC_DETECT_TIMEOUT_EN
          else if (tick) begin
            if (tmr_nxt == RTO) begin
              state      <= HOLDOFF;
              outTraffic <= 1'b0;
              outTimeout <= 1'b1;
              tmr        <= '0;
              veh_cnt    <= '0;
            end else begin
              tmr <= tmr_nxt;
            end
          end
`endif
        end
        HOLDOFF: begin
          if (tick) begin
            if (tmr_nxt == HLD) begin
              state <= IDLE;
              tmr   <= '0;
            end else begin
              tmr <= tmr_nxt;
            end
          end
        end
        default: begin
          state      <= IDLE;
          outTraffic <= 1'b0;
          veh_cnt    <= '0;
          tmr        <= '0;
        end
      endcase
    end
  end

`ifndef TRAFFIC_DETECT_TIMEOUT_EN
  assign outTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_detect.sv
// tb_traffic_detect: randomized and directed stimulus for traffic_detect,
// scoreboarded against an event-level reference model.
module tb_traffic_detect;

  localparam int THR  = 3;
  localparam int WIN  = 5;
  localparam int HOLD = 2;
  localparam int RTO  = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          blink = 1'b0;
  logic          inVehicle = 1'b0;
  logic          inAck = 1'b0;
  logic          outTraffic;
  logic [CW-1:0] outCount;
  logic          outTimeout;

  traffic_detect #(
    .C_THRESHOLD  (THR),
    .C_WINDOW     (WIN),
    .C_HOLDOFF    (HOLD),
    .C_REQ_TIMEOUT(RTO),
    .C_CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .blink     (blink),
    .inVehicle (inVehicle),
    .inAck     (inAck),
    .outTraffic(outTraffic),
    .outCount  (outCount),
    .outTimeout(outTimeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int traffic;
    int count;
    int timeout;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // level history as seen by the DUT input samplers (newest first)
  bit hb[3];
  bit hv[3];

  // reference model: request pending, holdoff blinks left,
  // vehicles/blinks inside the current window (0 vehicles = idle)
  int  m_count;
  bit  m_pend;
  bit  m_to;
  int  m_hold_left;
  int  m_win_veh;
  int  m_win_ticks;
  int  m_req_ticks;

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_count = 0;
    m_pend = 0;
    m_to = 0;
    m_hold_left = 0;
    m_win_veh = 0;
    m_win_ticks = 0;
    m_req_ticks = 0;
    for (int i = 0; i < 3; i++) begin
      hb[i] = 0;
      hv[i] = 0;
    end
  endfunction

  function automatic void model_edge(bit t, bit v, bit a);
    if (v && m_count < CMAX) m_count++;
    if (m_pend) begin
      if (a) begin
        m_pend = 0;
        m_hold_left = HOLD;
      end else begin
`ifdef TRAFFIC_DETECT_TIMEOUT_EN
        if (t) begin
          m_req_ticks++;
          if (m_req_ticks >= RTO) begin
            m_pend = 0;
            m_hold_left = HOLD;
            m_to = 1;
          end
        end
`endif
      end
    end else if (m_hold_left > 0) begin
      if (t) m_hold_left--;
    end else if (m_win_veh > 0) begin
      if (v && m_win_veh + 1 >= THR) begin
        m_pend = 1;
        m_req_ticks = 0;
        m_win_veh = 0;
      end else if (t && m_win_ticks + 1 >= WIN) begin
        m_win_veh = 0;
        m_win_ticks = 0;
      end else begin
        m_win_veh += int'(v);
        m_win_ticks += int'(t);
      end
    end else if (v) begin
      if (THR == 1) begin
        m_pend = 1;
        m_req_ticks = 0;
      end else begin
        m_win_veh = 1;
        m_win_ticks = 0;
      end
    end
  endfunction

  // one clock of stimulus; the DUT sees an input rise one edge
  // after it samples it, hence the use of hb[1]/hb[2]
  task automatic step(bit b, bit v, bit a);
    exp_t e;
    @(negedge clk);
    blink = b;
    inVehicle = v;
    inAck = a;
    hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = b;
    hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = v;
    model_edge(hb[1] & ~hb[2], hv[1] & ~hv[2], a);
    e.traffic = int'(m_pend);
    e.count = m_count;
    e.timeout = int'(m_to);
    q.push_back(e);
  endtask

  task automatic veh_p();
    step(0, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic tick_p(int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
  endtask

  task automatic ack_p();
    step(0, 0, 1);
    step(0, 0, 0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rstb = 1'b0;
    #1;
    check("rst_traffic", int'(outTraffic), 0);
    check("rst_count", int'(outCount), 0);
    check("rst_timeout", int'(outTimeout), 0);
    blink = 1'b0;
    inVehicle = 1'b0;
    inAck = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("traffic", int'(outTraffic), e.traffic);
        check("count", int'(outCount), e.count);
        check("timeout", int'(outTimeout), e.timeout);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    model_reset();
    repeat (3) @(negedge clk);
    check("init_traffic", int'(outTraffic), 0);
    check("init_count", int'(outCount), 0);
    check("init_timeout", int'(outTimeout), 0);
    rstb = 1'b1;

    // threshold within the window, ack, holdoff, restart
    veh_p(); tick_p(1); veh_p(); veh_p(); idle(3);
    ack_p(); idle(2); tick_p(2); idle(2);
    veh_p(); idle(2); tick_p(5); idle(2);

    // window expiry, then a lone vehicle
    veh_p(); veh_p(); tick_p(5); idle(2);
    veh_p(); idle(2); tick_p(5); idle(2);

    // third vehicle on the expiring tick
    veh_p(); veh_p(); tick_p(4);
    step(1, 1, 0); step(0, 0, 0); idle(2);
    ack_p(); tick_p(2); idle(2);

    // saturation, vehicles in holdoff, ack in idle
    for (int i = 0; i < 9; i++) veh_p();
    idle(2); ack_p(); veh_p(); veh_p();
    tick_p(2); idle(1);
    ack_p(); step(0, 0, 1); step(0, 0, 1); idle(3);

    // async reset in the middle of a request
    async_reset();
    veh_p(); veh_p(); veh_p(); idle(2);
    async_reset();
    veh_p(); veh_p(); veh_p(); idle(2);
    ack_p(); tick_p(2); idle(2);

`ifdef TRAFFIC_DETECT_TIMEOUT_EN
    // ack on the blink that would time out
    veh_p(); veh_p(); veh_p(); tick_p(3);
    step(1, 0, 0); step(0, 0, 1); idle(2);
    tick_p(2); idle(2);
    // unacknowledged request times out, flag sticks
    veh_p(); veh_p(); veh_p(); tick_p(4); idle(2);
    tick_p(2); veh_p(); veh_p(); veh_p(); idle(2);
    ack_p(); tick_p(2); idle(2);
`else
    // request held indefinitely without ack
    veh_p(); veh_p(); veh_p(); tick_p(200); idle(2);
    ack_p(); tick_p(2); idle(2);
`endif

    // random traffic
    async_reset();
    for (int i = 0; i < 1500; i++) begin
      step(bit'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    check("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
